// File: rtl/rr_arb_ctrl.sv
// rr_arb_ctrl: round-robin arbiter with grant hold and forced release.
// One owner at a time, one idle cycle between owners.
module rr_arb_ctrl #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] req_i,
    input  logic             done_i,
    output logic [WIDTH-1:0] gnt_o,
    output logic             gnt_valid_o,
    output logic [IDW-1:0]   gnt_id_o,
    output logic             timeout_o
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] gnt_q, gnt_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             to_q, to_d;

    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] sel;
    logic [IDW-1:0]   sel_id;
    logic [IDW-1:0]   ptr_next;
    logic             owner_req;
    logic             others;
    logic             at_limit;

    // Lowest set bit at or above ptr, else lowest set bit overall.
    always_comb begin
        masked = '0;
        sel    = '0;
        sel_id = '0;
        for (int i = 0; i < WIDTH; i++) begin
            masked[i] = req_i[i] && (i >= int'(ptr_q));
        end
        cand = (|masked) ? masked : req_i;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
                sel_id = IDW'(i);
            end
        end
    end

    // Release qualifiers for the current owner.
    always_comb begin
        owner_req = req_i[id_q];
        others    = |(req_i & ~gnt_q);
        at_limit  = (hold_q == HW'(MAX_HOLD));
        if (id_q == IDW'(WIDTH - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = id_q + IDW'(1);
        end
    end

    // Next-state and grant bookkeeping.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = GRANT;
                    gnt_d   = sel;
                    id_d    = sel_id;
                    hold_d  = HW'(1);
                end
            end
            GRANT: begin
                if (done_i || !owner_req || (at_limit && others)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    id_d    = '0;
                    ptr_d   = ptr_next;
                    hold_d  = '0;
                    // done and owner withdrawal both win over the limit
                    to_d    = !done_i && owner_req;
                end else if (!at_limit) begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                id_d    = '0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = |gnt_q;
    assign gnt_id_o    = id_q;
    assign timeout_o   = to_q;

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// tb_rr_arb_ctrl: scenario bench for the round-robin arbiter.
// Expected grants are queued per step and popped after each edge.
module tb_rr_arb_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] req_i = 8'h00;
    logic       done_i = 1'b0;
    logic [7:0] gnt_o;
    logic       gnt_valid_o;
    logic [2:0] gnt_id_o;
    logic       timeout_o;

    rr_arb_ctrl #(
        .WIDTH   (8),
        .MAX_HOLD(16)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .done_i     (done_i),
        .gnt_o      (gnt_o),
        .gnt_valid_o(gnt_valid_o),
        .gnt_id_o   (gnt_id_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       to;
    } stim_t;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    function automatic stim_t mk(input logic r, input logic [7:0] q,
                                 input logic d, input logic [7:0] g,
                                 input logic [2:0] id, input logic t);
        stim_t s;
        s.rst  = r;
        s.req  = q;
        s.done = d;
        s.gnt  = g;
        s.id   = id;
        s.to   = t;
        return s;
    endfunction

    task automatic test_reset();
        stim_t p[$];
        p.push_back(mk(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0));
        p.push_back(mk(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b0));
        foreach (p[i]) begin
            exp_t e;
            exp_t got;
            rst_i  = p[i].rst;
            req_i  = p[i].req;
            done_i = p[i].done;
            sb.push_back('{p[i].gnt, p[i].id, |p[i].gnt, p[i].to});
            @(posedge clk_i);
            #1;
            e   = sb.pop_front();
            got = '{gnt_o, gnt_id_o, gnt_valid_o, timeout_o};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL reset[%0d]: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
                         i, got.gnt, got.id, got.vld, got.to, e.gnt, e.id, e.vld, e.to);
            end
        end
    endtask

    task automatic test_rotation();
        stim_t p[$];
        p.push_back(mk(1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0));
        for (int o = 1; o <= 8; o++) begin
            logic [7:0] g;
            logic [2:0] id;
            id = 3'(o % 8);
            g  = 8'h01 << id;
            for (int c = 0; c < 3; c++) begin
                p.push_back(mk(1'b0, 8'hFF, 1'b0, g, id, 1'b0));
            end
            p.push_back(mk(1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0));
        end
        foreach (p[i]) begin
            exp_t e;
            exp_t got;
            rst_i  = p[i].rst;
            req_i  = p[i].req;
            done_i = p[i].done;
            sb.push_back('{p[i].gnt, p[i].id, |p[i].gnt, p[i].to});
            @(posedge clk_i);
            #1;
            e   = sb.pop_front();
            got = '{gnt_o, gnt_id_o, gnt_valid_o, timeout_o};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL rotation[%0d]: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
                         i, got.gnt, got.id, got.vld, got.to, e.gnt, e.id, e.vld, e.to);
            end
        end
    endtask

    task automatic test_wrap();
        stim_t p[$];
        p.push_back(mk(1'b0, 8'h20, 1'b0, 8'h20, 3'd5, 1'b0));
        p.push_back(mk(1'b0, 8'h20, 1'b1, 8'h00, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'h09, 1'b0, 8'h01, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'h09, 1'b1, 8'h00, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'h80, 1'b0, 8'h80, 3'd7, 1'b0));
        p.push_back(mk(1'b0, 8'h80, 1'b1, 8'h00, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'h09, 1'b0, 8'h01, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'h09, 1'b1, 8'h00, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'h09, 1'b0, 8'h08, 3'd3, 1'b0));
        p.push_back(mk(1'b0, 8'h09, 1'b1, 8'h00, 3'd0, 1'b0));
        foreach (p[i]) begin
            exp_t e;
            exp_t got;
            rst_i  = p[i].rst;
            req_i  = p[i].req;
            done_i = p[i].done;
            sb.push_back('{p[i].gnt, p[i].id, |p[i].gnt, p[i].to});
            @(posedge clk_i);
            #1;
            e   = sb.pop_front();
            got = '{gnt_o, gnt_id_o, gnt_valid_o, timeout_o};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL wrap[%0d]: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
                         i, got.gnt, got.id, got.vld, got.to, e.gnt, e.id, e.vld, e.to);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t p[$];
        for (int c = 0; c < 16; c++) begin
            p.push_back(mk(1'b0, 8'h03, 1'b0, 8'h01, 3'd0, 1'b0));
        end
        p.push_back(mk(1'b0, 8'h03, 1'b0, 8'h00, 3'd0, 1'b1));
        p.push_back(mk(1'b0, 8'h03, 1'b0, 8'h02, 3'd1, 1'b0));
        p.push_back(mk(1'b0, 8'h03, 1'b1, 8'h00, 3'd0, 1'b0));
        for (int c = 0; c < 45; c++) begin
            p.push_back(mk(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b0));
        end
        p.push_back(mk(1'b0, 8'h01, 1'b1, 8'h00, 3'd0, 1'b0));
        foreach (p[i]) begin
            exp_t e;
            exp_t got;
            rst_i  = p[i].rst;
            req_i  = p[i].req;
            done_i = p[i].done;
            sb.push_back('{p[i].gnt, p[i].id, |p[i].gnt, p[i].to});
            @(posedge clk_i);
            #1;
            e   = sb.pop_front();
            got = '{gnt_o, gnt_id_o, gnt_valid_o, timeout_o};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL timeout[%0d]: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
                         i, got.gnt, got.id, got.vld, got.to, e.gnt, e.id, e.vld, e.to);
            end
        end
    endtask

    task automatic test_withdraw_simul();
        stim_t p[$];
        for (int c = 0; c < 3; c++) begin
            p.push_back(mk(1'b0, 8'h04, 1'b0, 8'h04, 3'd2, 1'b0));
        end
        p.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0));
        for (int c = 0; c < 16; c++) begin
            p.push_back(mk(1'b0, 8'h0F, 1'b0, 8'h08, 3'd3, 1'b0));
        end
        p.push_back(mk(1'b0, 8'h0F, 1'b1, 8'h00, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0));
        foreach (p[i]) begin
            exp_t e;
            exp_t got;
            rst_i  = p[i].rst;
            req_i  = p[i].req;
            done_i = p[i].done;
            sb.push_back('{p[i].gnt, p[i].id, |p[i].gnt, p[i].to});
            @(posedge clk_i);
            #1;
            e   = sb.pop_front();
            got = '{gnt_o, gnt_id_o, gnt_valid_o, timeout_o};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL withdraw[%0d]: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
                         i, got.gnt, got.id, got.vld, got.to, e.gnt, e.id, e.vld, e.to);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        stim_t p[$];
        p.push_back(mk(1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b0));
        p.push_back(mk(1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b0));
        p.push_back(mk(1'b1, 8'h10, 1'b0, 8'h00, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'h11, 1'b0, 8'h01, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'h11, 1'b1, 8'h00, 3'd0, 1'b0));
        p.push_back(mk(1'b0, 8'h11, 1'b0, 8'h10, 3'd4, 1'b0));
        p.push_back(mk(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0));
        foreach (p[i]) begin
            exp_t e;
            exp_t got;
            rst_i  = p[i].rst;
            req_i  = p[i].req;
            done_i = p[i].done;
            sb.push_back('{p[i].gnt, p[i].id, |p[i].gnt, p[i].to});
            @(posedge clk_i);
            #1;
            e   = sb.pop_front();
            got = '{gnt_o, gnt_id_o, gnt_valid_o, timeout_o};
            vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL rst_mid[%0d]: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
                         i, got.gnt, got.id, got.vld, got.to, e.gnt, e.id, e.vld, e.to);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_wrap();
        test_timeout();
        test_withdraw_simul();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arb_ctrl.md
Name: rr_arb_ctrl

Overview:
Sequential round-robin arbiter and grant controller that shares one downstream resource (event/bus port) among WIDTH requesters. It uses fixed-priority lowest-index selection over a rotating mask to pick a single owner. It then holds that grant until the owner releases it or a hold limit expires, and advances the priority pointer past the served requester. It sits between the requester ports and the shared datapath mux, driving its one-hot select.

Parameters:
WIDTH, 8, number of requesters (>=2).
MAX_HOLD, 16, maximum consecutive grant cycles before forced release when other requests are pending (>=1).
IDW, $clog2(WIDTH), width of the grant index.

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  synchronous active-high reset.
req_i  input  WIDTH  request per requester; level, held until served.
done_i  input  1  current owner finished; sampled only in GRANT.
gnt_o  output  WIDTH  registered one-hot grant; all-zero when no owner.
gnt_valid_o  output  1  high when gnt_o is non-zero (equals |gnt_o).
gnt_id_o  output  IDW  binary index of the owner; 0 when gnt_valid_o=0.
timeout_o  output  1  one-cycle pulse on a forced release by MAX_HOLD.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, gnt_o=0, gnt_valid_o=0, gnt_id_o=0, timeout_o=0, ptr=0, hold_cnt=0. Reset mid-grant drops the grant on the next edge, with no timeout pulse.
- Selection (combinational, used in IDLE only):
  - masked = req_i & ~((1<<ptr)-1).
  - If masked is non-zero, pick the lowest set bit of masked. Otherwise pick the lowest set bit of req_i (wrap-around).
  - Result is one-hot or zero.
- FSM states: IDLE, GRANT.
- IDLE:
  - gnt_o=0.
  - If |req_i: next state GRANT, gnt_o<=selection, gnt_id_o<=its index, hold_cnt<=1.
  - Latency: req_i asserted at edge N -> gnt_o visible after edge N+1 (1 cycle).
- GRANT: gnt_o held constant. Release conditions, evaluated each cycle in priority order:
  1. done_i=1.
  2. req_i[gnt_id_o]=0 (owner withdrew).
  3. hold_cnt==MAX_HOLD and (req_i & ~gnt_o)!=0. This case also pulses timeout_o=1 for one cycle, coincident with the cycle gnt_o goes to 0.
- On release:
  - state<=IDLE, gnt_o<=0, gnt_id_o<=0.
  - ptr<=(gnt_id_o+1) mod WIDTH. WIDTH-1 wraps to 0.
- If no release condition holds: hold_cnt<=hold_cnt+1, saturating at MAX_HOLD. A sole requester keeps the grant indefinitely; the counter stays at MAX_HOLD and no timeout fires.
- Handover always inserts exactly one idle cycle (gnt_o=0) between owners. No cycle ever has two grant bits set.
- Simultaneous done_i and timeout in the same cycle: treated as done_i, so timeout_o=0.
- Requests arriving during GRANT are not visible until the next IDLE arbitration. A request dropped before selection is simply not granted.
- ptr changes only on release and on reset.

Test Plan:
- Reset/idle: rst_i=1 for 2 cycles with req_i=8'hFF -> gnt_o=0, gnt_id_o=0, timeout_o=0. Release reset -> after 1 edge gnt_o=8'h01, gnt_id_o=0.
- Round-robin rotation: req_i=8'hFF held, done_i pulsed on the 3rd grant cycle of each owner -> grants 01,02,04,...,80,01 in order, each separated by exactly one zero cycle. ptr wraps from 7 to 0.
- Wrap selection: after owner 5 releases (ptr=6), req_i=8'h09 -> gnt_o=8'h01 (id 0). With ptr=0 and req_i=8'h09 -> gnt_o=8'h01 again; after release ptr=1 -> gnt_o=8'h08.
- Timeout: MAX_HOLD=16, req_i=8'h03, done_i=0 -> gnt_o=01 for exactly 16 cycles, then timeout_o=1 for one cycle with gnt_o=0, then gnt_o=02. Same with req_i=8'h01 only -> grant held 40+ cycles, timeout_o never asserts.
- Owner withdrawal and simultaneity: owner 2 drops req_i[2] mid-grant -> gnt_o=0 next edge and ptr=3. done_i=1 exactly at hold_cnt==16 with others pending -> release with timeout_o=0.
- Reset mid-grant: assert rst_i while gnt_o=8'h10 -> next edge gnt_o=0, ptr=0. After reset with req_i=8'h11 -> gnt_o=8'h01.
